// File: rtl/inv_cipher_round.sv
// AES-128 inverse-cipher round stage (FIPS-197 InvCipher).
// The state path is InvShiftRows, then InvSubBytes, then AddRoundKey, then
// InvMixColumns. The last stage is left out when FINAL=1.
// The key path steps K(ROUND+1) back to K(ROUND) with the inverse key
// schedule. It then forwards K(ROUND) in step with the state, so a chain of
// these stages only needs K10 at its input.
// FINAL=1 only makes sense with ROUND=0.
module inv_cipher_round #(
    parameter int ROUND = 9,
    parameter int FINAL = 0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         i_tx_en,
    input  logic [127:0] i_state,
    input  logic [127:0] i_round_key,
    output logic         o_tx_en,
    output logic [127:0] o_state,
    output logic [127:0] o_round_key
);

    // Forward S-box. The inverse S-box is derived from this same table,
    // so only one table exists in the design.
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Round constant used when stepping the key back from K(idx) to K(idx-1).
    function automatic logic [7:0] rcon_of(input int idx);
        case (idx)
            1:       rcon_of = 8'h01;
            2:       rcon_of = 8'h02;
            3:       rcon_of = 8'h04;
            4:       rcon_of = 8'h08;
            5:       rcon_of = 8'h10;
            6:       rcon_of = 8'h20;
            7:       rcon_of = 8'h40;
            8:       rcon_of = 8'h80;
            9:       rcon_of = 8'h1b;
            10:      rcon_of = 8'h36;
            default: rcon_of = 8'h00;
        endcase
    endfunction

    localparam logic [7:0] RCON = rcon_of(ROUND + 1);

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[x];
    endfunction

    // Inverse of the S-box affine map. It is applied to every input bit:
    // rotl 1, rotl 3 and rotl 6 are XORed together, then XOR 0x05.
    function automatic logic [7:0] inv_affine(input logic [7:0] x);
        return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    endfunction

    // S(x) = A(x^-1), so x^-1 = A^-1(S(x)).
    // This gives InvS(y) = (A^-1(y))^-1 = A^-1(S(A^-1(y))).
    function automatic logic [7:0] inv_sbox(input logic [7:0] y);
        return inv_affine(sbox(inv_affine(y)));
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Row r rotates right by r. Output byte n takes input byte (n - 4*r) mod 16.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int n = 0; n < 16; n++) begin
            r[127 - 8*n -: 8] = s[127 - 8*((n + 16 - 4*(n % 4)) % 16) -: 8];
        end
        return r;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int n = 0; n < 16; n++) begin
            r[127 - 8*n -: 8] = inv_sbox(s[127 - 8*n -: 8]);
        end
        return r;
    endfunction

    // Each column is multiplied by the circulant matrix {0e,0b,0d,09}.
    // The 9/b/d/e multiples come from a chain of xtime steps.
    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a   [4];
        logic [7:0]   m9  [4];
        logic [7:0]   m11 [4];
        logic [7:0]   m13 [4];
        logic [7:0]   m14 [4];
        logic [7:0]   x2, x4, x8;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 4; i++) begin
                a[i]   = s[127 - 8*(4*c + i) -: 8];
                x2     = xtime(a[i]);
                x4     = xtime(x2);
                x8     = xtime(x4);
                m9[i]  = x8 ^ a[i];
                m11[i] = x8 ^ x2 ^ a[i];
                m13[i] = x8 ^ x4 ^ a[i];
                m14[i] = x8 ^ x4 ^ x2;
            end
            r[127 - 8*(4*c)     -: 8] = m14[0] ^ m11[1] ^ m13[2] ^ m9[3];
            r[127 - 8*(4*c + 1) -: 8] = m9[0]  ^ m14[1] ^ m11[2] ^ m13[3];
            r[127 - 8*(4*c + 2) -: 8] = m13[0] ^ m9[1]  ^ m14[2] ^ m11[3];
            r[127 - 8*(4*c + 3) -: 8] = m11[0] ^ m13[1] ^ m9[2]  ^ m14[3];
        end
        return r;
    endfunction

    // One inverse key schedule step, from K(ROUND+1) to K(ROUND).
    function automatic logic [127:0] inv_key_step(input logic [127:0] k);
        logic [31:0] w0, w1, w2, w3, p0, p1, p2, p3, t;
        {w0, w1, w2, w3} = k;
        p3 = w3 ^ w2;
        p2 = w2 ^ w1;
        p1 = w1 ^ w0;
        t  = {sbox(p3[23:16]), sbox(p3[15:8]), sbox(p3[7:0]), sbox(p3[31:24])};
        p0 = w0 ^ t ^ {RCON, 24'h000000};
        return {p0, p1, p2, p3};
    endfunction

    logic         s1_valid, s2_valid, s3_valid;
    logic [127:0] s1_state, s2_state, s3_state;
    logic [127:0] s1_key,   s2_key,   s3_key;

    // Stage 1: InvShiftRows on the state, and one inverse key schedule step on the key.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: reset is in the sensitivity list so the pipe clears without waiting for a clock edge.
        if (reset) begin
            s1_valid <= 1'b0;
            s1_state <= '0;
            s1_key   <= '0;
        end else begin
            // NOTE: non-blocking assignments make each stage sample the value its
            // upstream stage held before the edge.
            s1_valid <= i_tx_en;
            // NOTE: an invalid slot loads zeros. Stale or undefined input data is
            // therefore never carried down the pipe.
            s1_state <= i_tx_en ? inv_shift_rows(i_state)   : '0;
            s1_key   <= i_tx_en ? inv_key_step(i_round_key) : '0;
        end
    end

    // Stage 2: InvSubBytes on the state. The key is delayed by one cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_state <= '0;
            s2_key   <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_state <= s1_valid ? inv_sub_bytes(s1_state) : '0;
            s2_key   <= s1_valid ? s1_key                  : '0;
        end
    end

    // Stage 3: AddRoundKey with K(ROUND). The key moves forward alongside the state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s3_valid <= 1'b0;
            s3_state <= '0;
            s3_key   <= '0;
        end else begin
            s3_valid <= s2_valid;
            s3_state <= s2_valid ? (s2_state ^ s2_key) : '0;
            s3_key   <= s2_valid ? s2_key              : '0;
        end
    end

    generate
        if (FINAL != 0) begin : g_final
            assign o_tx_en     = s3_valid;
            assign o_state     = s3_state;
            assign o_round_key = s3_key;
        end else begin : g_mix
            logic         s4_valid;
            logic [127:0] s4_state;
            logic [127:0] s4_key;

            // Stage 4: InvMixColumns on the state. The key is delayed by one cycle.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    s4_valid <= 1'b0;
                    s4_state <= '0;
                    s4_key   <= '0;
                end else begin
                    s4_valid <= s3_valid;
                    s4_state <= s3_valid ? inv_mix_columns(s3_state) : '0;
                    s4_key   <= s3_valid ? s3_key                    : '0;
                end
            end

            assign o_tx_en     = s4_valid;
            assign o_state     = s4_state;
            assign o_round_key = s4_key;
        end
    endgenerate

endmodule

// File: tb/tb_inv_cipher_round.sv
// Self-checking bench for inv_cipher_round.
// It drives a standalone ROUND=9 stage, a standalone ROUND=0 final stage, and
// a ten-stage decryptor chain.
// Expected values come from FIPS-197 C.1 constants or from a forward-cipher
// model that builds its own S-box by arithmetic.
module tb_inv_cipher_round;

    logic clock = 1'b0;
    logic reset = 1'b1;

    int n_vectors = 0;
    int n_miscompares = 0;

    logic [7:0] sb [256];
    logic [7:0] inv_v;

    // Standalone ROUND=9 normal stage.
    logic         r9_en;
    logic [127:0] r9_state, r9_key;
    logic         r9_o_en;
    logic [127:0] r9_o_state, r9_o_key;

    // Standalone ROUND=0 final stage.
    logic         r0_en;
    logic [127:0] r0_state, r0_key;
    logic         r0_o_en;
    logic [127:0] r0_o_state, r0_o_key;

    // Ten-stage chain, ROUND 9 down to 0.
    logic         ch_in_en;
    logic [127:0] ch_in_state, ch_in_key;
    wire          ch_en    [0:10];
    wire  [127:0] ch_state [0:10];
    wire  [127:0] ch_key   [0:10];

    assign ch_en[0]    = ch_in_en;
    assign ch_state[0] = ch_in_state;
    assign ch_key[0]   = ch_in_key;

    always #5 clock = ~clock;

    inv_cipher_round #(.ROUND(9), .FINAL(0)) u_r9 (
        .clock(clock), .reset(reset), .i_tx_en(r9_en), .i_state(r9_state), .i_round_key(r9_key),
        .o_tx_en(r9_o_en), .o_state(r9_o_state), .o_round_key(r9_o_key)
    );

    inv_cipher_round #(.ROUND(0), .FINAL(1)) u_r0 (
        .clock(clock), .reset(reset), .i_tx_en(r0_en), .i_state(r0_state), .i_round_key(r0_key),
        .o_tx_en(r0_o_en), .o_state(r0_o_state), .o_round_key(r0_o_key)
    );

    for (genvar i = 0; i < 10; i++) begin : g_chain
        inv_cipher_round #(.ROUND(9 - i), .FINAL(i == 9 ? 1 : 0)) u_round (
            .clock(clock), .reset(reset),
            .i_tx_en(ch_en[i]), .i_state(ch_state[i]), .i_round_key(ch_key[i]),
            .o_tx_en(ch_en[i+1]), .o_state(ch_state[i+1]), .o_round_key(ch_key[i+1])
        );
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- forward-cipher model ----------------
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        for (int n = 0; n < 16; n++) r[127 - 8*n -: 8] = sb[s[127 - 8*n -: 8]];
        return r;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        for (int n = 0; n < 16; n++) r[127 - 8*n -: 8] = s[127 - 8*((n + 4*(n % 4)) % 16) -: 8];
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            {a0, a1, a2, a3} = s[127 - 32*c -: 32];
            r[127 - 32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                                   a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                   a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                                   xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
        end
        return r;
    endfunction

    function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        {w0, w1, w2, w3} = k;
        t  = {sb[w3[23:16]], sb[w3[15:8]], sb[w3[7:0]], sb[w3[31:24]]} ^ {rc, 24'h0};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    task automatic encrypt(input logic [127:0] pt, input logic [127:0] k0,
                           output logic [127:0] ct, output logic [127:0] k10);
        logic [127:0] s, k;
        logic [7:0]   rc;
        k = k0; s = pt ^ k0; rc = 8'h01;
        for (int r = 1; r <= 10; r++) begin
            k = next_key(k, rc);
            s = shift_rows(sub_bytes(s));
            if (r != 10) s = mix_columns(s);
            s = s ^ k;
            rc = xt(rc);
        end
        ct = s; k10 = k;
    endtask

    // The ROUND=9 stage maps (s, K10) to (o, K9).
    // Given o and K9, this produces the stage inputs by running the forward round.
    task automatic make_r9(input logic [127:0] o, input logic [127:0] k9,
                           output logic [127:0] s, output logic [127:0] k10);
        k10 = next_key(k9, 8'h36);
        s   = shift_rows(sub_bytes(mix_columns(o) ^ k9));
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- stimulus ----------------
    logic [127:0] v_o [5], v_k9 [5], v_s [5], v_k10 [5];
    logic [127:0] c_pt [16], c_k0 [16], c_in [16], c_k10 [16];
    logic [127:0] tmp_ct;
    int           pattern [5] = '{1, 0, 1, 1, 0};
    int           got_n;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        r9_en = 0; r9_state = '0; r9_key = '0;
        r0_en = 0; r0_state = '0; r0_key = '0;
        ch_in_en = 0; ch_in_state = '0; ch_in_key = '0;

        // The S-box is built from first principles: GF(2^8) inverse followed by the affine map.
        for (int a = 0; a < 256; a++) begin
            inv_v = 8'h00;
            for (int b = 1; b < 256; b++) if (gmul(8'(a), 8'(b)) == 8'h01) inv_v = 8'(b);
            sb[a] = inv_v ^ {inv_v[6:0], inv_v[7]} ^ {inv_v[5:0], inv_v[7:6]}
                          ^ {inv_v[4:0], inv_v[7:5]} ^ {inv_v[3:0], inv_v[7:4]} ^ 8'h63;
        end

        // Outputs while reset is held.
        repeat (3) @(negedge clock);
        check("rst_r9_en",    128'(r9_o_en), 128'd0);
        check("rst_r9_state", r9_o_state,    128'd0);
        check("rst_r9_key",   r9_o_key,      128'd0);
        check("rst_r0_en",    128'(r0_o_en), 128'd0);
        check("rst_chain_en", 128'(ch_en[10]), 128'd0);
        reset = 1'b0;

        // FIPS C.1 vectors: inverse round 1 on the ROUND=9 stage, the final round on the ROUND=0 stage.
        @(negedge clock);
        r9_en = 1; r9_state = 128'h7ad5fda789ef4e272bca100b3d9ff59f; r9_key = 128'h13111d7fe3944a17f307a78b4d2b30c5;
        r0_en = 1; r0_state = 128'h6353e08c0960e104cd70b751bacad0e7; r0_key = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clock);
            if (c == 1) begin
                r9_en = 0; r9_state = '0; r9_key = '0;
                r0_en = 0; r0_state = '0; r0_key = '0;
            end
            if (c == 2) check("r0_en_early", 128'(r0_o_en), 128'd0);
            if (c == 3) begin
                check("r0_en",    128'(r0_o_en), 128'd1);
                check("r0_state", r0_o_state, 128'h00112233445566778899aabbccddeeff);
                check("r0_key",   r0_o_key,   128'h000102030405060708090a0b0c0d0e0f);
                check("r9_en_early", 128'(r9_o_en), 128'd0);
            end
            if (c == 4) begin
                check("r9_en",    128'(r9_o_en), 128'd1);
                check("r9_state", r9_o_state, 128'h54d990a16ba09ab596bbf40ea111702f);
                check("r9_key",   r9_o_key,   128'h549932d1f08557681093ed9cbe2c974e);
                check("r0_en_single", 128'(r0_o_en), 128'd0);
            end
        end

        // Bubble pattern 1,0,1,1,0 on the ROUND=9 stage.
        for (int i = 0; i < 5; i++) begin
            v_o[i] = rand128(); v_k9[i] = rand128();
            make_r9(v_o[i], v_k9[i], v_s[i], v_k10[i]);
        end
        for (int c = 0; c < 9; c++) begin
            @(negedge clock);
            if (c >= 4) begin
                check($sformatf("bub_en[%0d]", c - 4), 128'(r9_o_en), 128'(pattern[c-4]));
                check($sformatf("bub_state[%0d]", c - 4), r9_o_state, pattern[c-4] != 0 ? v_o[c-4] : 128'd0);
                check($sformatf("bub_key[%0d]", c - 4), r9_o_key, pattern[c-4] != 0 ? v_k9[c-4] : 128'd0);
            end
            if (c < 5 && pattern[c] != 0) begin
                r9_en = 1; r9_state = v_s[c]; r9_key = v_k10[c];
            end else begin
                r9_en = 0; r9_state = 128'hdead_beef_0000_1111_2222_3333_4444_5555; r9_key = rand128();
            end
        end
        r9_state = '0; r9_key = '0;

        // Full chain with the FIPS C.1 ciphertext, after the external AddRoundKey with K10.
        @(negedge clock);
        ch_in_en = 1;
        ch_in_key = 128'h13111d7fe3944a17f307a78b4d2b30c5;
        ch_in_state = 128'h69c4e0d86a7b0430d8cdb78070b4c55a ^ ch_in_key;
        for (int c = 1; c <= 39; c++) begin
            @(negedge clock);
            if (c == 1) begin ch_in_en = 0; ch_in_state = '0; ch_in_key = '0; end
            if (c == 38) check("chain_en_early", 128'(ch_en[10]), 128'd0);
            if (c == 39) begin
                check("chain_en",  128'(ch_en[10]), 128'd1);
                check("chain_pt",  ch_state[10], 128'h00112233445566778899aabbccddeeff);
                check("chain_key", ch_key[10],   128'h000102030405060708090a0b0c0d0e0f);
            end
        end

        // Sixteen random back-to-back blocks, each with its own key.
        for (int i = 0; i < 16; i++) begin
            c_pt[i] = rand128(); c_k0[i] = rand128();
            encrypt(c_pt[i], c_k0[i], tmp_ct, c_k10[i]);
            c_in[i] = tmp_ct ^ c_k10[i];
        end
        got_n = 0;
        for (int c = 0; c < 16 + 39 + 4; c++) begin
            @(negedge clock);
            if (ch_en[10]) begin
                if (got_n < 16) begin
                    check($sformatf("rand_pt[%0d]", got_n),  ch_state[10], c_pt[got_n]);
                    check($sformatf("rand_key[%0d]", got_n), ch_key[10],   c_k0[got_n]);
                    if (got_n == 0) check("rand_first_cycle", 128'(c), 128'd39);
                end else begin
                    check("rand_extra_output", 128'd1, 128'd0);
                end
                got_n++;
            end
            if (c < 16) begin
                ch_in_en = 1; ch_in_state = c_in[c]; ch_in_key = c_k10[c];
            end else begin
                ch_in_en = 0; ch_in_state = '0; ch_in_key = '0;
            end
        end
        check("rand_count", 128'(got_n), 128'd16);

        // Gating: inputs carry X or noise while valid stays low.
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            check($sformatf("gate_en[%0d]", c),    128'(r9_o_en), 128'd0);
            check($sformatf("gate_state[%0d]", c), r9_o_state,    128'd0);
            check($sformatf("gate_key[%0d]", c),   r9_o_key,      128'd0);
            r9_en = 0;
            if (c < 5) begin r9_state = 'x; r9_key = 'x; end
            else       begin r9_state = rand128(); r9_key = rand128(); end
        end

        // Reset arrives mid-flight: block 0 is at the output and three more are behind it.
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            r9_en = 1; r9_state = v_s[c]; r9_key = v_k10[c];
        end
        @(negedge clock);
        check("mid_pre_en", 128'(r9_o_en), 128'd1);
        r9_en = 0; r9_state = '0; r9_key = '0;
        #2 reset = 1'b1;
        #1;
        check("mid_rst_en",    128'(r9_o_en), 128'd0);
        check("mid_rst_state", r9_o_state,    128'd0);
        check("mid_rst_key",   r9_o_key,      128'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            check($sformatf("post_rst_idle[%0d]", c), 128'(r9_o_en), 128'd0);
        end
        r9_en = 1; r9_state = 128'h7ad5fda789ef4e272bca100b3d9ff59f; r9_key = 128'h13111d7fe3944a17f307a78b4d2b30c5;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clock);
            if (c == 1) begin r9_en = 0; r9_state = '0; r9_key = '0; end
            if (c == 3) check("post_rst_en_early", 128'(r9_o_en), 128'd0);
            if (c == 4) begin
                check("post_rst_en",    128'(r9_o_en), 128'd1);
                check("post_rst_state", r9_o_state, 128'h54d990a16ba09ab596bbf40ea111702f);
                check("post_rst_key",   r9_o_key,   128'h549932d1f08557681093ed9cbe2c974e);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
